// File: rtl/qdec_nal_unpacker_pkg.sv
// qdec_nal_unpacker_pkg: shared NAL parser states, header layout and byte constants.
package qdec_nal_unpacker_pkg;
    typedef enum logic [1:0] {SEARCH, HDR0, HDR1, PAYLOAD} t_nal_state_e;
    localparam int NAL_TYPE_VCL_MAX = 31;
    localparam logic [7:0] NAL_EPB_BYTE = 8'h03;
    localparam logic [7:0] NAL_SC_BYTE = 8'h01;
    typedef struct packed {
        logic [5:0] nal_type;
        logic [5:0] layer_id;
        logic [2:0] tid;
    } t_nal_hdr_s;
endpackage

// File: rtl/qdec_nal_unpacker_skid.sv
// qdec_byte_skid: one-entry byte output register with valid/ready.
module qdec_byte_skid (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       load,
    input  logic [7:0] d,
    output logic       free,
    output logic [7:0] q,
    output logic       vld,
    input  logic       rdy
);
    assign free = !vld || rdy;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= 1'b0;
            q   <= 8'h00;
        end else if (clr) begin
            vld <= 1'b0;
        end else if (free) begin
            vld <= load;
            if (load) q <= d;
        end
    end
endmodule

// File: rtl/qdec_nal_unpacker.sv
// qdec_nal_unpacker: Annex-B start-code search, NAL header parse and emulation-prevention strip.
// Define QDEC_NAL_EPB_STAT_EN to add the epb_cnt/nal_cnt statistics outputs.
module qdec_nal_unpacker
    import qdec_nal_unpacker_pkg::*;
#(
    parameter bit DROP_NON_VCL = 1'b1,
    parameter int CNT_W        = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             soft_clr,
    input  logic [7:0]       din,
    input  logic             din_vld,
    output logic             din_rdy,
    output logic [7:0]       dout,
    output logic             dout_vld,
    input  logic             dout_rdy,
    output logic             nal_hdr_vld,
    output logic [5:0]       nal_type,
    output logic [5:0]       nal_layer_id,
    output logic [2:0]       nal_tid,
    output logic             nal_end,
    output logic [CNT_W-1:0] nal_byte_cnt,
    output logic             error_intr
`ifdef QDEC_NAL_EPB_STAT_EN
    ,
    output logic [15:0]      epb_cnt,
    output logic [15:0]      nal_cnt
`endif
);
    t_nal_state_e state, state_nx;
    t_nal_hdr_s   hdr;
    logic [1:0]   zero_cnt, pend, pend_nx, flush, flush_nx;
    logic [7:0]   h0, held, ld_byte;
    logic         held_vld, held_nx, free, acc, ld, drop, end_p, err, hdr_cap, epb;

    assign din_rdy      = free && flush == 2'd0 && !held_vld && !soft_clr;
    assign acc          = din_vld && din_rdy;
    assign drop         = DROP_NON_VCL && hdr.nal_type > 6'(NAL_TYPE_VCL_MAX);
    assign nal_type     = hdr.nal_type;
    assign nal_layer_id = hdr.layer_id;
    assign nal_tid      = hdr.tid;

    qdec_byte_skid u_skid (
        .clk  (clk),
        .rst  (rst),
        .clr  (soft_clr),
        .load (ld && !drop),
        .d    (ld_byte),
        .free (free),
        .q    (dout),
        .vld  (dout_vld),
        .rdy  (dout_rdy)
    );

    always_comb begin
        state_nx = state;
        pend_nx  = pend;
        flush_nx = flush;
        held_nx  = held_vld;
        ld       = 1'b0;
        ld_byte  = din;
        end_p    = 1'b0;
        err      = 1'b0;
        hdr_cap  = 1'b0;
        epb      = 1'b0;
        if (flush != 2'd0) begin
            ld       = free;
            ld_byte  = 8'h00;
            flush_nx = free ? flush - 2'd1 : flush;
        end else if (held_vld) begin
            ld      = free;
            ld_byte = held;
            held_nx = !free;
        end else if (acc) begin
            case (state)
                SEARCH: state_nx = (din == NAL_SC_BYTE && zero_cnt[1]) ? HDR0 : SEARCH;
                HDR0: begin
                    err      = din[7];
                    state_nx = din[7] ? SEARCH : HDR1;
                end
                HDR1: begin
                    err      = din[2:0] == 3'd0;
                    hdr_cap  = 1'b1;
                    pend_nx  = 2'd0;
                    state_nx = PAYLOAD;
                end
                PAYLOAD: begin
                    pend_nx = 2'd0;
                    // zeros are held back until the next byte proves they are not a start code
                    if (din == 8'h00 && pend != 2'd2) begin
                        pend_nx = pend + 2'd1;
                    end else if (pend != 2'd2) begin
                        flush_nx = pend;
                        held_nx  = pend != 2'd0;
                        ld       = pend == 2'd0;
                    end else if (din == NAL_EPB_BYTE) begin
                        epb      = 1'b1;
                        flush_nx = 2'd2;
                    end else if (din >= 8'h04) begin
                        flush_nx = 2'd2;
                        held_nx  = 1'b1;
                    end else begin
                        end_p    = din != 8'h02;
                        err      = din == 8'h02;
                        state_nx = din == NAL_SC_BYTE ? HDR0 : SEARCH;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= SEARCH;
            zero_cnt     <= 2'd0;
            pend         <= 2'd0;
            flush        <= 2'd0;
            held_vld     <= 1'b0;
            held         <= 8'h00;
            h0           <= 8'h00;
            hdr          <= '0;
            nal_hdr_vld  <= 1'b0;
            nal_end      <= 1'b0;
            nal_byte_cnt <= '0;
            error_intr   <= 1'b0;
        end else if (soft_clr) begin
            state       <= SEARCH;
            zero_cnt    <= 2'd0;
            pend        <= 2'd0;
            flush       <= 2'd0;
            held_vld    <= 1'b0;
            nal_hdr_vld <= 1'b0;
            nal_end     <= 1'b0;
            error_intr  <= 1'b0;
        end else begin
            state       <= state_nx;
            pend        <= pend_nx;
            flush       <= flush_nx;
            held_vld    <= held_nx;
            nal_hdr_vld <= hdr_cap;
            nal_end     <= end_p;
            if (err) error_intr <= 1'b1;
            if (acc) zero_cnt <= (din != 8'h00) ? 2'd0 : (&zero_cnt ? zero_cnt : zero_cnt + 2'd1);
            if (acc) held <= din;
            if (acc && state == HDR0) h0 <= din;
            if (hdr_cap) hdr <= '{h0[6:1], {h0[0], din[7:3]}, din[2:0] - 3'd1};
            if (hdr_cap) nal_byte_cnt <= '0;
            else if (dout_vld && dout_rdy && !(&nal_byte_cnt)) nal_byte_cnt <= nal_byte_cnt + 1'b1;
        end
    end

`ifdef QDEC_NAL_EPB_STAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            epb_cnt <= 16'd0;
            nal_cnt <= 16'd0;
        end else if (soft_clr) begin
            epb_cnt <= 16'd0;
            nal_cnt <= 16'd0;
        end else begin
            if (epb && !(&epb_cnt)) epb_cnt <= epb_cnt + 16'd1;
            if (hdr_cap) nal_cnt <= nal_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_qdec_nal_unpacker.sv
// tb_qdec_nal_unpacker: scenario bench with byte scoreboard for the NAL unpacker.
module tb_qdec_nal_unpacker;
    import qdec_nal_unpacker_pkg::*;

    logic        clk = 1'b0, rst = 1'b1, soft_clr = 1'b0, din_vld = 1'b0, dout_rdy = 1'b1;
    logic [7:0]  din = 8'h00;
    logic        din_rdy, dout_vld, nal_hdr_vld, nal_end, error_intr;
    logic [7:0]  dout;
    logic [5:0]  nal_type, nal_layer_id;
    logic [2:0]  nal_tid;
    logic [23:0] nal_byte_cnt;
    logic        dd_din_rdy, dd_dout_vld, dd_nal_hdr_vld, dd_nal_end, dd_error_intr;
    logic [7:0]  dd_dout;
    logic [5:0]  dd_nal_type, dd_nal_layer_id;
    logic [2:0]  dd_nal_tid;
    logic [23:0] dd_nal_byte_cnt;
`ifdef QDEC_NAL_EPB_STAT_EN
    logic [15:0] epb_cnt, nal_cnt, dd_epb_cnt, dd_nal_cnt;
`endif

    int checks = 0, errors = 0;
    int hdr_seen = 0, end_seen = 0, stab_viol = 0, dd_vld = 0;
    bit rdy_toggle = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_dout = 8'h00;
    logic [7:0] exp_q[$], obs_q[$], stim[$];

    qdec_nal_unpacker #(.DROP_NON_VCL(1'b0), .CNT_W(24)) dut (
        .clk(clk), .rst(rst), .soft_clr(soft_clr), .din(din), .din_vld(din_vld), .din_rdy(din_rdy),
        .dout(dout), .dout_vld(dout_vld), .dout_rdy(dout_rdy), .nal_hdr_vld(nal_hdr_vld),
        .nal_type(nal_type), .nal_layer_id(nal_layer_id), .nal_tid(nal_tid), .nal_end(nal_end),
        .nal_byte_cnt(nal_byte_cnt), .error_intr(error_intr)
`ifdef QDEC_NAL_EPB_STAT_EN
        , .epb_cnt(epb_cnt), .nal_cnt(nal_cnt)
`endif
    );

    qdec_nal_unpacker dd (
        .clk(clk), .rst(rst), .soft_clr(soft_clr), .din(din), .din_vld(din_vld), .din_rdy(dd_din_rdy),
        .dout(dd_dout), .dout_vld(dd_dout_vld), .dout_rdy(dout_rdy), .nal_hdr_vld(dd_nal_hdr_vld),
        .nal_type(dd_nal_type), .nal_layer_id(dd_nal_layer_id), .nal_tid(dd_nal_tid), .nal_end(dd_nal_end),
        .nal_byte_cnt(dd_nal_byte_cnt), .error_intr(dd_error_intr)
`ifdef QDEC_NAL_EPB_STAT_EN
        , .epb_cnt(dd_epb_cnt), .nal_cnt(dd_nal_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) dout_rdy = rdy_toggle ? ~dout_rdy : 1'b1;

    always @(negedge clk) begin
        #2;
        if (prev_stall && (!dout_vld || dout !== prev_dout)) stab_viol++;
        if (dout_vld && dout_rdy) obs_q.push_back(dout);
        if (nal_hdr_vld) hdr_seen++;
        if (nal_end) end_seen++;
        if (dd_dout_vld) dd_vld++;
        prev_stall = dout_vld && !dout_rdy;
        prev_dout  = dout;
    end

    task automatic send_stim();
        foreach (stim[k]) begin
            int t = 0;
            @(negedge clk); #1;
            din = stim[k];
            din_vld = 1'b1;
            while (!din_rdy && t < 100) begin
                @(negedge clk); #1;
                t++;
            end
            if (t >= 100) begin
                checks++; errors++;
                $display("FAIL send_timeout byte=%h din_rdy=0 required=1", stim[k]);
            end
            @(posedge clk); #1;
            din_vld = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_soft_clr();
        @(negedge clk); #1 soft_clr = 1'b1;
        @(negedge clk); #1 soft_clr = 1'b0;
    endtask

    task automatic test_reset();
        idle(2);
        checks++;
        if ({dout_vld, nal_hdr_vld, nal_end, error_intr, dout, nal_type, nal_layer_id, nal_tid, nal_byte_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs vld=%b hdr=%b end=%b err=%b dout=%h type=%h cnt=%h required all 0",
                     dout_vld, nal_hdr_vld, nal_end, error_intr, dout, nal_type, nal_byte_cnt);
        end
        checks++;
        if (dut.state !== SEARCH) begin errors++; $display("FAIL reset_state got=%0d required=%0d", dut.state, SEARCH); end
        @(negedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_basic();
        int h = hdr_seen, e = end_seen, d = dd_vld;
        exp_q = '{8'hAA, 8'hBB};
        stim = '{8'h00, 8'h00, 8'h01, 8'h40, 8'h01, 8'hAA, 8'hBB, 8'h00, 8'h00, 8'h01};
        send_stim();
        idle(6);
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_count got=%0d required=%0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_byte%0d required=%h", i, exp_q[i]); end
        end
        obs_q.delete(); exp_q.delete();
        checks++; if (hdr_seen - h != 1) begin errors++; $display("FAIL basic_hdr_pulses got=%0d required=1", hdr_seen - h); end
        checks++; if (nal_type !== 6'd32) begin errors++; $display("FAIL basic_type got=%0d required=32", nal_type); end
        checks++; if (nal_tid !== 3'd0) begin errors++; $display("FAIL basic_tid got=%0d required=0", nal_tid); end
        checks++; if (nal_layer_id !== 6'd0) begin errors++; $display("FAIL basic_layer got=%0d required=0", nal_layer_id); end
        checks++; if (end_seen - e != 1) begin errors++; $display("FAIL basic_end_pulses got=%0d required=1", end_seen - e); end
        checks++; if (dut.state !== HDR0) begin errors++; $display("FAIL basic_state got=%0d required=%0d", dut.state, HDR0); end
        checks++; if (nal_byte_cnt !== 24'd2) begin errors++; $display("FAIL basic_byte_cnt got=%0d required=2", nal_byte_cnt); end
        checks++; if (dd_vld - d != 0) begin errors++; $display("FAIL drop_dout_vld got=%0d cycles required=0", dd_vld - d); end
        checks++; if (dd_nal_byte_cnt !== 24'd0) begin errors++; $display("FAIL drop_byte_cnt got=%0d required=0", dd_nal_byte_cnt); end
        checks++; if (dd_nal_type !== 6'd32) begin errors++; $display("FAIL drop_type got=%0d required=32", dd_nal_type); end
    endtask

    task automatic test_epb(input bit stall);
        int h = hdr_seen, e = end_seen, s = stab_viol;
        pulse_soft_clr();
        rdy_toggle = stall;
        exp_q = '{8'h11, 8'h00, 8'h00, 8'h00, 8'h22};
        stim = '{8'h00, 8'h00, 8'h01, 8'h26, 8'h01, 8'h11, 8'h00, 8'h00, 8'h03, 8'h00, 8'h22, 8'h00, 8'h00, 8'h01};
        send_stim();
        idle(12);
        rdy_toggle = 1'b0;
        idle(2);
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL epb_count stall=%0d got=%0d required=%0d", stall, obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL epb_byte%0d stall=%0d required=%h", i, stall, exp_q[i]); end
        end
        obs_q.delete(); exp_q.delete();
        checks++; if (nal_byte_cnt !== 24'd5) begin errors++; $display("FAIL epb_byte_cnt stall=%0d got=%0d required=5", stall, nal_byte_cnt); end
        checks++; if (nal_type !== 6'd19) begin errors++; $display("FAIL epb_type got=%0d required=19", nal_type); end
        checks++; if (hdr_seen - h != 1 || end_seen - e != 1) begin errors++; $display("FAIL epb_pulses hdr=%0d end=%0d required 1 and 1", hdr_seen - h, end_seen - e); end
        checks++; if (stab_viol - s != 0) begin errors++; $display("FAIL epb_stall_stability violations=%0d required=0", stab_viol - s); end
        checks++; if (error_intr !== 1'b0) begin errors++; $display("FAIL epb_error got=%b required=0", error_intr); end
`ifdef QDEC_NAL_EPB_STAT_EN
        checks++; if (epb_cnt !== 16'd1) begin errors++; $display("FAIL epb_cnt got=%0d required=1", epb_cnt); end
        checks++; if (nal_cnt !== 16'd1) begin errors++; $display("FAIL nal_cnt got=%0d required=1", nal_cnt); end
`endif
    endtask

    task automatic test_error();
        int h;
        pulse_soft_clr();
        h = hdr_seen;
        stim = '{8'h00, 8'h00, 8'h01, 8'hA6, 8'h01};
        send_stim();
        idle(4);
        checks++; if (error_intr !== 1'b1) begin errors++; $display("FAIL forbidden_error got=%b required=1", error_intr); end
        checks++; if (dut.state !== SEARCH) begin errors++; $display("FAIL forbidden_state got=%0d required=%0d", dut.state, SEARCH); end
        checks++; if (obs_q.size() != 0 || hdr_seen - h != 0) begin errors++; $display("FAIL forbidden_quiet dout=%0d hdr=%0d required 0 and 0", obs_q.size(), hdr_seen - h); end
        obs_q.delete();
        pulse_soft_clr();
        checks++; if (error_intr !== 1'b0) begin errors++; $display("FAIL soft_clr_error got=%b required=0", error_intr); end
        h = hdr_seen;
        stim = '{8'h00, 8'h00, 8'h01, 8'h26, 8'h00};
        send_stim();
        idle(4);
        checks++; if (error_intr !== 1'b1) begin errors++; $display("FAIL tid_zero_error got=%b required=1", error_intr); end
        checks++; if (hdr_seen - h != 1 || nal_tid !== 3'd7) begin errors++; $display("FAIL tid_zero_hdr pulses=%0d tid=%0d required 1 and 7", hdr_seen - h, nal_tid); end
    endtask

    task automatic test_back_to_back();
        int h, e;
        pulse_soft_clr();
        h = hdr_seen; e = end_seen;
        exp_q = '{8'h55};
        stim = '{8'h00, 8'h00, 8'h01, 8'h26, 8'h01, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h26, 8'h01};
        send_stim();
        idle(6);
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin errors++; $display("FAIL b2b_dout count=%0d required one byte %h", obs_q.size(), exp_q[0]); end
        obs_q.delete(); exp_q.delete();
        checks++; if (hdr_seen - h != 2) begin errors++; $display("FAIL b2b_hdr_pulses got=%0d required=2", hdr_seen - h); end
        checks++; if (end_seen - e != 1) begin errors++; $display("FAIL b2b_end_pulses got=%0d required=1", end_seen - e); end
        checks++; if (dut.state !== PAYLOAD) begin errors++; $display("FAIL b2b_state got=%0d required=%0d", dut.state, PAYLOAD); end
        checks++; if (nal_byte_cnt !== 24'd0) begin errors++; $display("FAIL b2b_byte_cnt got=%0d required=0", nal_byte_cnt); end
    endtask

    task automatic test_rst_mid();
        int h, e, d;
        pulse_soft_clr();
        stim = '{8'h00, 8'h00, 8'h01, 8'h26, 8'h01, 8'h00, 8'h00};
        send_stim();
        idle(2);
        checks++; if (dut.pend !== 2'd2) begin errors++; $display("FAIL rst_mid_pend got=%0d required=2", dut.pend); end
        e = end_seen;
        @(negedge clk); #3 rst = 1'b1;
        #1;
        checks++;
        if ({dout_vld, nal_hdr_vld, nal_end, error_intr, dout, nal_type, nal_layer_id, nal_tid, nal_byte_cnt} !== '0) begin
            errors++;
            $display("FAIL rst_mid_async vld=%b type=%h tid=%h cnt=%h required all 0", dout_vld, nal_type, nal_tid, nal_byte_cnt);
        end
        @(negedge clk); #1 rst = 1'b0;
        idle(2);
        checks++; if (end_seen - e != 0) begin errors++; $display("FAIL rst_mid_no_end got=%0d required=0", end_seen - e); end
        h = hdr_seen; e = end_seen; d = dd_vld;
        exp_q = '{8'h77};
        stim = '{8'h00, 8'h00, 8'h01, 8'h26, 8'h03, 8'h77, 8'h00, 8'h00, 8'h01};
        send_stim();
        idle(6);
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin errors++; $display("FAIL resync_dout count=%0d required one byte %h", obs_q.size(), exp_q[0]); end
        obs_q.delete(); exp_q.delete();
        checks++; if (hdr_seen - h != 1 || nal_tid !== 3'd2) begin errors++; $display("FAIL resync_hdr pulses=%0d tid=%0d required 1 and 2", hdr_seen - h, nal_tid); end
        checks++; if (nal_byte_cnt !== 24'd1 || end_seen - e != 1) begin errors++; $display("FAIL resync_cnt cnt=%0d end=%0d required 1 and 1", nal_byte_cnt, end_seen - e); end
        checks++; if (dd_vld - d != 1 || dd_nal_byte_cnt !== 24'd1) begin errors++; $display("FAIL vcl_forward dd_vld=%0d cnt=%0d required 1 and 1", dd_vld - d, dd_nal_byte_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_epb(1'b0);
        test_epb(1'b1);
        test_error();
        test_back_to_back();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/qdec_nal_unpacker.md
Name: qdec_nal_unpacker

Overview:
- Byte-stream front end that sits directly upstream of qdec_cabac.
- Consumes the raw Annex-B HEVC byte stream from the bitstream FIFO and locates start codes (00 00 01).
- Parses the 2-byte NAL unit header and strips emulation-prevention bytes (00 00 03 -> 00 00).
- Forwards clean RBSP payload bytes on the valid/ready byte interface that drives bitstreamFetch/bitstreamFetch_vld/bitstreamFetch_rdy.

Parameters:
DROP_NON_VCL, 1, when 1 payload of NAL units with nal_type >= 32 is consumed but not forwarded
CNT_W, 24, width of the per-NAL forwarded-byte counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
soft_clr  in  1  synchronous clear: drop pending state, return to SEARCH
din  in  8  raw stream byte from bitstream FIFO
din_vld  in  1  din valid
din_rdy  out  1  din accepted when din_vld&din_rdy
dout  out  8  RBSP byte to CABAC (bitstreamFetch)
dout_vld  out  1  dout valid
dout_rdy  in  1  CABAC ready
nal_hdr_vld  out  1  one-cycle pulse: header fields valid
nal_type  out  6  header byte0[6:1], held until next header
nal_layer_id  out  6  {byte0[0], byte1[7:3]}
nal_tid  out  3  byte1[2:0] minus 1
nal_end  out  1  one-cycle pulse: current NAL terminated
nal_byte_cnt  out  CNT_W  bytes forwarded in current NAL, saturating
error_intr  out  1  sticky; cleared by rst or soft_clr

Behaviour:
- Clock and reset: one clock clk; reset rst is asynchronous, active-high. All outputs reset to 0; state = SEARCH; zero_cnt = 0.
- Single output register stage: dout/dout_vld change only when !dout_vld or dout_rdy. dout holds stable while dout_vld && !dout_rdy.
- Input handshake: din_rdy = output slot free (or draining this cycle) && not flushing held zeros. No combinational din_vld->din_rdy path.
- zero_cnt: 2-bit saturating count of consecutive accepted 0x00 bytes.
- SEARCH: consume bytes, no output. Byte 0x01 with zero_cnt >= 2 -> HDR0.
- HDR0: capture byte. If bit7 (forbidden_zero) = 1, set error_intr and go to SEARCH. Otherwise -> HDR1.
- HDR1: capture byte; nal_tid = byte[2:0]-1. If byte[2:0] == 0, set error_intr. Pulse nal_hdr_vld the cycle after capture. Clear nal_byte_cnt. -> PAYLOAD.
- PAYLOAD, pending zeros: a 0x00 byte is not forwarded immediately; pend = min(pend+1, 2).
- PAYLOAD, next byte after pend = 2:
  - 0x03 -> emit the two zeros, drop 0x03, pend = 0.
  - 0x01 -> drop zeros, pulse nal_end -> HDR0.
  - 0x00 -> drop zeros, pulse nal_end -> SEARCH (trailing/leading zero bytes).
  - 0x02 -> error_intr, -> SEARCH.
  - >= 0x04 -> emit zeros then the byte.
- PAYLOAD, any other non-zero byte with pend > 0: emit the held zeros one per output cycle with din_rdy low, then the byte.
- Emission latency: 1 cycle from accept to dout_vld when no zeros are pending.
- DROP_NON_VCL = 1 and nal_type >= 32: identical parsing, but dout_vld is never raised and nal_byte_cnt stays 0.
- nal_byte_cnt increments per dout handshake and saturates at all-ones.
- soft_clr overrides same-cycle input (byte not accepted); dout_vld deasserts the next cycle.
- rst mid-NAL: pending zeros are discarded and no nal_end is pulsed.

Optional Feature:
- Macro: QDEC_NAL_EPB_STAT_EN.
- With it: adds output epb_cnt[15:0], a saturating count of 0x03 bytes stripped since rst/soft_clr, plus output nal_cnt[15:0], a count of nal_hdr_vld pulses.
- Without it: neither port nor its counters exists; all other behaviour is identical.

Decomposition:
- qdec_cabac_package gains:
  - enum t_nal_state_e {SEARCH, HDR0, HDR1, PAYLOAD}
  - constants NAL_TYPE_VCL_MAX=31, NAL_EPB_BYTE=8'h03, NAL_SC_BYTE=8'h01
  - struct t_nal_hdr_s {type, layer_id, tid}
- One sub-module, qdec_byte_skid: a one-entry output register with valid/ready.

Test Plan:
- Bytes 00 00 01 40 01 AA BB 00 00 01 -> nal_hdr_vld with nal_type=32, tid=0; with DROP_NON_VCL=0, dout = AA,BB; nal_end pulse; state HDR0.
- 00 00 01 26 01 11 00 00 03 00 22 00 00 01 -> dout = 11,00,00,00,22; nal_byte_cnt=5; epb_cnt=1 when macro defined.
- Same stream with dout_rdy toggling 1010… -> identical dout sequence, no loss/duplication, dout stable while stalled.
- 00 00 01 A6 01 -> error_intr=1 (forbidden bit), no dout, state SEARCH; soft_clr clears error_intr.
- 00 00 01 26 01 55 00 00 00 00 01 26 01 -> dout=55 only; one nal_end; second nal_hdr_vld.
- rst asserted while pend=2 mid-PAYLOAD -> all outputs 0 asynchronously; next 00 00 01 resynchronises.
